// File: rtl/rot_pkg.sv
// Shared types and constants for the rotate arbiter slice.
// Optional feature macro: ROT_LEFT_EN (adds per-requester rotate-left).
package rot_pkg;

    localparam int DATA_W  = 8;
    localparam int SHAMT_W = 3;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_e;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

    // Left rotate by s equals right rotate by (DATA_W - s) mod DATA_W.
    function automatic logic [SHAMT_W-1:0] left_to_right(
        input logic [SHAMT_W-1:0] s
    );
        logic [SHAMT_W-1:0] zero;
        zero = '0;
        return zero - s;
    endfunction

endpackage

// File: rtl/rot8_core.sv
// Combinational 8-bit rotate-right: out[i] = in[(i + shift) mod 8].
module rot8_core
    import rot_pkg::*;
(
    input  logic [DATA_W-1:0]  in_i,
    input  logic [SHAMT_W-1:0] shift_i,
    output logic [DATA_W-1:0]  out_o
);

    logic [2*DATA_W-1:0] dbl;

    assign dbl   = {in_i, in_i} >> shift_i;
    assign out_o = dbl[DATA_W-1:0];

endmodule

// File: rtl/rot_arbiter.sv
// Two requesters share one rotator; round-robin grant into a 1-deep result slot.
// Optional macro ROT_LEFT_EN adds dir_a_i/dir_b_i (1 = rotate left).
module rot_arbiter #(
    parameter int DATA_W  = 8,
    parameter int SHAMT_W = 3
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               valid_a_i,
    input  logic [DATA_W-1:0]  in_a_i,
    input  logic [SHAMT_W-1:0] shift_a_i,
`ifdef ROT_LEFT_EN
    input  logic               dir_a_i,
`endif
    output logic               ready_a_o,
    input  logic               valid_b_i,
    input  logic [DATA_W-1:0]  in_b_i,
    input  logic [SHAMT_W-1:0] shift_b_i,
`ifdef ROT_LEFT_EN
    input  logic               dir_b_i,
`endif
    output logic               ready_b_o,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [DATA_W-1:0]  out_o,
    output logic               out_src_o
);

    import rot_pkg::*;

    slot_e              state_q;
    src_e               src_q;
    src_e               last_q;
    logic [DATA_W-1:0]  out_q;

    logic               slot_free;
    logic               grant_a;
    logic               grant_b;
    logic               grant;
    src_e               src_d;
    logic [DATA_W-1:0]  mux_data;
    logic [SHAMT_W-1:0] mux_shamt;
    logic [SHAMT_W-1:0] core_shamt;
    logic [DATA_W-1:0]  out_d;

    // Reset gates the grant so no READY leaks out while rst_ni is low.
    assign slot_free = rst_ni && ((state_q == EMPTY) || out_ready_i);

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (slot_free) begin
            unique case ({valid_a_i, valid_b_i})
                2'b10: grant_a = 1'b1;
                2'b01: grant_b = 1'b1;
                2'b11: begin
                    if (last_q == SRC_B) grant_a = 1'b1;
                    else                 grant_b = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign grant     = grant_a | grant_b;
    assign src_d     = grant_b ? SRC_B : SRC_A;
    assign ready_a_o = grant_a;
    assign ready_b_o = grant_b;

    always_comb begin
        mux_data  = in_a_i;
        mux_shamt = shift_a_i;
        unique case (1'b1)
            grant_b: begin
                mux_data  = in_b_i;
                mux_shamt = shift_b_i;
            end
            default: ;
        endcase
    end

`ifdef ROT_LEFT_EN
    logic mux_left;

    assign mux_left   = grant_b ? dir_b_i : dir_a_i;
    assign core_shamt = mux_left ? left_to_right(mux_shamt) : mux_shamt;
`else
    assign core_shamt = mux_shamt;
`endif

    rot8_core u_core (
        .in_i    (mux_data),
        .shift_i (core_shamt),
        .out_o   (out_d)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            out_q   <= '0;
            src_q   <= SRC_A;
            last_q  <= SRC_B;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (grant) begin
                        state_q <= FULL;
                        out_q   <= out_d;
                        src_q   <= src_d;
                        last_q  <= src_d;
                    end
                end
                FULL: begin
                    if (grant) begin
                        out_q  <= out_d;
                        src_q  <= src_d;
                        last_q <= src_d;
                    end else if (out_ready_i) begin
                        state_q <= EMPTY;
                    end
                end
            endcase
        end
    end

    assign out_valid_o = (state_q == FULL);
    assign out_o       = out_q;
    assign out_src_o   = src_q;

endmodule

// File: tb/tb_rot_arbiter.sv
// Table-driven bench for rot_arbiter with a result scoreboard queue.
module tb_rot_arbiter;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic       clk;
    logic       rst_n;
    logic       valid_a, valid_b;
    logic [7:0] in_a, in_b;
    logic [2:0] shift_a, shift_b;
    logic       dir_a, dir_b;
    logic       ready_a, ready_b;
    logic       out_valid, out_ready;
    logic [7:0] out_d;
    logic       out_src;

    typedef struct {
        logic       va;
        logic [7:0] ina;
        logic [2:0] sha;
        logic       da;
        logic       vb;
        logic [7:0] inb;
        logic [2:0] shb;
        logic       db;
        logic       ordy;
        logic       exp_ra;
        logic       exp_rb;
    } vec_t;

    typedef struct packed {
        logic [7:0] data;
        logic       src;
    } exp_t;

    exp_t q[$];
    vec_t tbl[17];
    int   checks = 0;
    int   errors = 0;

    rot_arbiter dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .valid_a_i   (valid_a),
        .in_a_i      (in_a),
        .shift_a_i   (shift_a),
`ifdef ROT_LEFT_EN
        .dir_a_i     (dir_a),
`endif
        .ready_a_o   (ready_a),
        .valid_b_i   (valid_b),
        .in_b_i      (in_b),
        .shift_b_i   (shift_b),
`ifdef ROT_LEFT_EN
        .dir_b_i     (dir_b),
`endif
        .ready_b_o   (ready_b),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_o       (out_d),
        .out_src_o   (out_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model_rot(
        input logic [7:0] d, input logic [2:0] s, input logic left
    );
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            if (left) r[i] = d[(i + 8 - int'(s)) % 8];
            else      r[i] = d[(i + int'(s)) % 8];
        end
        return r;
    endfunction

    function automatic vec_t mk(
        input logic va, input logic [7:0] ina, input logic [2:0] sha,
        input logic vb, input logic [7:0] inb, input logic [2:0] shb,
        input logic ordy, input logic ra, input logic rb
    );
        vec_t v;
        v.va = va; v.ina = ina; v.sha = sha; v.da = L;
        v.vb = vb; v.inb = inb; v.shb = shb; v.db = L;
        v.ordy = ordy; v.exp_ra = ra; v.exp_rb = rb;
        return v;
    endfunction

    task automatic chk(input string n, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        valid_a   = v.va;
        in_a      = v.ina;
        shift_a   = v.sha;
        dir_a     = v.da;
        valid_b   = v.vb;
        in_b      = v.inb;
        shift_b   = v.shb;
        dir_b     = v.db;
        out_ready = v.ordy;
        @(negedge clk);
        if (q.size() != 0) begin
            chk($sformatf("v%0d_out_valid", idx), 8'(out_valid), 8'h01);
            chk($sformatf("v%0d_out", idx), out_d, q[0].data);
            chk($sformatf("v%0d_out_src", idx), 8'(out_src), 8'(q[0].src));
            if (v.ordy) void'(q.pop_front());
        end else begin
            chk($sformatf("v%0d_out_valid", idx), 8'(out_valid), 8'h00);
        end
        chk($sformatf("v%0d_ready_a", idx), 8'(ready_a), 8'(v.exp_ra));
        chk($sformatf("v%0d_ready_b", idx), 8'(ready_b), 8'(v.exp_rb));
        if (v.exp_ra) q.push_back('{model_rot(v.ina, v.sha, v.da), 1'b0});
        if (v.exp_rb) q.push_back('{model_rot(v.inb, v.shb, v.db), 1'b1});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        vec_t v;

        tbl[0]  = mk(H, 8'h81, 3'd1, H, 8'h5A, 3'd0, H, H, L);
        tbl[1]  = mk(H, 8'h12, 3'd3, H, 8'h5A, 3'd4, H, L, H);
        tbl[2]  = mk(H, 8'hF0, 3'd5, H, 8'h3C, 3'd7, H, H, L);
        tbl[3]  = mk(H, 8'hFF, 3'd2, H, 8'h01, 3'd1, H, L, H);
        tbl[4]  = mk(H, 8'h11, 3'd6, H, 8'h22, 3'd2, L, L, L);
        tbl[5]  = mk(H, 8'h11, 3'd6, H, 8'h22, 3'd2, L, L, L);
        tbl[6]  = mk(H, 8'h11, 3'd6, H, 8'h22, 3'd2, L, L, L);
        tbl[7]  = mk(H, 8'h11, 3'd6, H, 8'h22, 3'd2, H, H, L);
        tbl[8]  = mk(L, 8'hEE, 3'd3, L, 8'hDD, 3'd5, H, L, L);
        tbl[9]  = mk(L, 8'h00, 3'd0, L, 8'h00, 3'd0, H, L, L);
        tbl[10] = mk(L, 8'h00, 3'd0, H, 8'h81, 3'd7, H, L, H);
        tbl[11] = mk(L, 8'h00, 3'd0, H, 8'h0F, 3'd2, H, L, H);
        tbl[12] = mk(H, 8'hAA, 3'd1, L, 8'h00, 3'd0, L, L, L);
        tbl[13] = mk(H, 8'hAA, 3'd1, L, 8'h00, 3'd0, H, H, L);
        tbl[14] = mk(L, 8'h00, 3'd0, L, 8'h00, 3'd0, H, L, L);
        tbl[15] = mk(L, 8'h00, 3'd0, H, 8'h5A, 3'd0, H, L, H);
        tbl[16] = mk(L, 8'h00, 3'd0, L, 8'h00, 3'd0, H, L, L);

        rst_n     = 1'b0;
        valid_a   = 1'b1;
        valid_b   = 1'b1;
        in_a      = 8'h33;
        in_b      = 8'h44;
        shift_a   = 3'd1;
        shift_b   = 3'd2;
        dir_a     = 1'b0;
        dir_b     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 8'(out_valid), 8'h00);
        chk("rst_out", out_d, 8'h00);
        chk("rst_out_src", 8'(out_src), 8'h00);
        chk("rst_ready_a", 8'(ready_a), 8'h00);
        chk("rst_ready_b", 8'(ready_b), 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) run_vec(tbl[i], i);

        // Fill the slot, then pull reset in the middle of a cycle.
        run_vec(mk(H, 8'h3C, 3'd2, L, 8'h00, 3'd0, L, H, L), 100);
        chk("fill_out_valid", 8'(out_valid), 8'h01);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 8'(out_valid), 8'h00);
        chk("async_rst_out", out_d, 8'h00);
        chk("async_rst_ready_a", 8'(ready_a), 8'h00);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_vec(mk(H, 8'h81, 3'd1, L, 8'h00, 3'd0, H, H, L), 101);
        chk("a81_out", out_d, 8'hC0);
        chk("a81_out_src", 8'(out_src), 8'h00);
        chk("a81_out_valid", 8'(out_valid), 8'h01);
        run_vec(mk(L, 8'h00, 3'd0, L, 8'h00, 3'd0, H, L, L), 102);

`ifdef ROT_LEFT_EN
        v    = mk(H, 8'h81, 3'd1, L, 8'h00, 3'd0, H, H, L);
        v.da = H;
        run_vec(v, 103);
        chk("left_out", out_d, 8'h03);
        run_vec(mk(L, 8'h00, 3'd0, L, 8'h00, 3'd0, H, L, L), 104);
`else
        v = mk(L, 8'h00, 3'd0, L, 8'h00, 3'd0, H, L, L);
        run_vec(v, 103);
`endif

        chk("sb_empty", 8'(q.size()), 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rot_arbiter.md
ROT_ARBITER -- requirements
Module: rot_arbiter

Interface
REQ-001 Parameter DATA_W, default 8: rotator data width, fixed at 8; other values unsupported.
REQ-002 Parameter SHAMT_W, default 3: rotate-amount width, equal to log2(DATA_W).
REQ-003 CLK  input  1  single clock; all state on rising edge.
REQ-004 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-005 VALID_A  input  1  requester A has a rotate job.
REQ-006 IN_A  input  8  requester A data.
REQ-007 SHIFT_A  input  3  requester A rotate amount.
REQ-008 READY_A  output  1  requester A job accepted this cycle.
REQ-009 VALID_B, IN_B, SHIFT_B, READY_B: same as REQ-005..008 for requester B.
REQ-010 OUT_VALID  output  1  result register holds a valid result.
REQ-011 OUT_READY  input  1  consumer accepts the result.
REQ-012 OUT  output  8  rotated result.
REQ-013 OUT_SRC  output  1  result owner: 0 = A, 1 = B.

Function
REQ-014 Shall share one 8-bit rotate-right datapath between A and B: OUT[i] = IN[(i+s) mod 8].
REQ-015 Result slot: two states, EMPTY (OUT_VALID=0) and FULL (OUT_VALID=1).
REQ-016 Slot is free when EMPTY, or when FULL with OUT_READY=1 (same-cycle drain and refill).
REQ-017 When the slot is free and at least one VALID is high, exactly one requester is granted; its READY is high combinationally in that cycle.
REQ-018 READY_A and READY_B shall never be high in the same cycle; READY shall be 0 when the slot is not free, even if VALID is high.
REQ-019 Arbitration: round-robin with a 1-bit last-grant pointer. With both requesting, grant the one not granted last. With one requesting, grant it regardless of the pointer.
REQ-020 The pointer updates only on a grant.
REQ-021 Latency is 1 cycle: the rotated data and source are registered on the accept edge; OUT_VALID is high from the next cycle.
REQ-022 Throughput: one result per cycle while OUT_READY=1.
REQ-023 While FULL and OUT_READY=0, OUT, OUT_SRC and OUT_VALID hold stable.
REQ-024 On drain with no grant, go to EMPTY. On drain with a grant, stay FULL with the new result.
REQ-025 SHIFT=0 passes data unchanged; SHIFT=7 equals rotate-left by 1.
REQ-026 Requester inputs are sampled only in the grant cycle; later changes do not affect a captured result.

Reset
REQ-027 When RST_N=0: state EMPTY, OUT_VALID=0, OUT=8'h00, OUT_SRC=0, pointer = B (so A wins the first contention).
REQ-028 Reset mid-transaction discards the held result; READY_A and READY_B are 0 while RST_N=0.
REQ-029 The first grant is possible in the first cycle with RST_N=1.

Configuration
REQ-030 Macro ROT_LEFT_EN, when defined, adds inputs DIR_A and DIR_B (1 bit each; 1 = rotate left).
REQ-031 Left rotate by s is implemented as right rotate by (8-s) mod 8 on the same shared datapath.
REQ-032 When ROT_LEFT_EN is undefined, the DIR ports do not exist and all rotations are right.

Structure
REQ-033 Shared package rot_pkg holds DATA_W, SHAMT_W, the state encoding (EMPTY/FULL) and the source encoding (SRC_A/SRC_B).
REQ-034 One sub-module, rot8_core: a combinational 8-bit rotate-right (IN, SHIFT, OUT), instantiated once.
REQ-035 The direction conversion and the input mux sit in rot_arbiter ahead of rot8_core.

Verification
REQ-036 A only, IN_A=8'h81, SHIFT_A=1, OUT_READY=1 -> READY_A in cycle 0; cycle 1: OUT=8'hC0, OUT_SRC=0, OUT_VALID=1.
REQ-037 A and B both valid after reset, held for 4 cycles, OUT_READY=1 -> grants A,B,A,B and OUT_SRC alternates 0,1,0,1.
REQ-038 Slot FULL, OUT_READY=0 for 3 cycles, both valid -> READY_A=READY_B=0 and OUT stable. Then OUT_READY=1 -> same-cycle drain and grant, OUT_VALID stays 1.
REQ-039 IN_B=8'h5A, SHIFT_B=0 -> OUT=8'h5A. SHIFT_B=4 -> OUT=8'hA5.
REQ-040 RST_N pulsed low while FULL -> OUT_VALID=0 and OUT=8'h00 immediately, asynchronous to CLK.
REQ-041 With ROT_LEFT_EN, IN_A=8'h81, SHIFT_A=1, DIR_A=1 -> OUT=8'h03.
